// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board dimension defaults, empty-cell colour and
// the line-clear engine state encoding.
package tetris_pkg;

  localparam int unsigned BOARD_W_DEF = 21;
  localparam int unsigned BOARD_H_DEF = 41;
  localparam int unsigned COLOR_W_DEF = 3;

  localparam logic [2:0] EMPTY_COLOR = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_RD,
    SCAN_CHK,
    SHIFT_RD,
    SHIFT_WR,
    DONE
  } row_clr_state_t;

endpackage

// File: rtl/tetris_row_clear.sv
// Line-clear engine: scans the SRAM board bottom-up, removes each full row by
// shifting every row above it down one, refills row 0 with the empty colour and
// reports the number of rows removed.
module tetris_row_clear #(
  parameter int unsigned          BOARD_W     = tetris_pkg::BOARD_W_DEF,
  parameter int unsigned          BOARD_H     = tetris_pkg::BOARD_H_DEF,
  parameter int unsigned          COLOR_W     = tetris_pkg::COLOR_W_DEF,
  parameter logic [COLOR_W-1:0]   EMPTY_COLOR = COLOR_W'(tetris_pkg::EMPTY_COLOR),
  parameter int unsigned          X_W         = $clog2(BOARD_W),
  parameter int unsigned          Y_W         = $clog2(BOARD_H),
  parameter int unsigned          L_W         = $clog2(BOARD_H + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] sram_rdata,
  output logic               busy,
  output logic               done,
  output logic [L_W-1:0]     lines_cleared,
  output logic               clr_pulse,
  output logic [Y_W-1:0]     clr_row,
  output logic               sram_re,
  output logic               sram_we,
  output logic [X_W-1:0]     sram_x,
  output logic [Y_W-1:0]     sram_y,
  output logic [COLOR_W-1:0] sram_wdata
);

  import tetris_pkg::*;

  localparam logic [X_W-1:0] X_LAST = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_H - 1);

  row_clr_state_t state, state_n;

  logic [X_W-1:0] x, x_n;
  logic [Y_W-1:0] y, y_n;
  logic [Y_W-1:0] sy, sy_n;
  logic [L_W-1:0] lines, lines_n;
  logic [L_W-1:0] lines_cleared_q, lines_cleared_n;
  logic [Y_W-1:0] clr_row_q, clr_row_n;
  logic           row_full;

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      x               <= '0;
      y               <= '0;
      sy              <= '0;
      lines           <= '0;
      lines_cleared_q <= '0;
      clr_row_q       <= '0;
    end else begin
      state           <= state_n;
      x               <= x_n;
      y               <= y_n;
      sy              <= sy_n;
      lines           <= lines_n;
      lines_cleared_q <= lines_cleared_n;
      clr_row_q       <= clr_row_n;
    end
  end

  // Next-state and counter update; row_full flags the last cell of a full row.
  always_comb begin
    state_n         = state;
    x_n             = x;
    y_n             = y;
    sy_n            = sy;
    lines_n         = lines;
    lines_cleared_n = lines_cleared_q;
    clr_row_n       = clr_row_q;
    row_full        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          x_n     = '0;
          y_n     = Y_LAST;
          lines_n = '0;
          state_n = SCAN_RD;
        end
      end
      SCAN_RD: state_n = SCAN_CHK;
      SCAN_CHK: begin
        if (sram_rdata == EMPTY_COLOR) begin
          if (y == '0) begin
            // Result is loaded on entry to DONE so it is valid alongside done.
            lines_cleared_n = lines;
            state_n         = DONE;
          end else begin
            y_n     = y - 1'b1;
            x_n     = '0;
            state_n = SCAN_RD;
          end
        end else if (x == X_LAST) begin
          row_full  = 1'b1;
          clr_row_n = y;
          lines_n   = lines + 1'b1;
          sy_n      = y;
          x_n       = '0;
          state_n   = SHIFT_RD;
        end else begin
          x_n     = x + 1'b1;
          state_n = SCAN_RD;
        end
      end
      SHIFT_RD: state_n = SHIFT_WR;
      SHIFT_WR: begin
        if (x == X_LAST) begin
          x_n = '0;
          if (sy == '0) begin
            // The row that dropped into y must itself be re-checked.
            state_n = SCAN_RD;
          end else begin
            sy_n    = sy - 1'b1;
            state_n = SHIFT_RD;
          end
        end else begin
          x_n     = x + 1'b1;
          state_n = SHIFT_RD;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Moore decode of status, strobes and addresses from state and counters.
  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    sram_re    = 1'b0;
    sram_we    = 1'b0;
    sram_x     = '0;
    sram_y     = '0;
    sram_wdata = '0;
    case (state)
      SCAN_RD: begin
        sram_re = 1'b1;
        sram_x  = x;
        sram_y  = y;
      end
      SCAN_CHK: begin
        sram_x = x;
        sram_y = y;
      end
      SHIFT_RD: begin
        sram_x = x;
        if (sy != '0) begin
          sram_re = 1'b1;
          sram_y  = sy - 1'b1;
        end
      end
      SHIFT_WR: begin
        sram_we    = 1'b1;
        sram_x     = x;
        sram_y     = sy;
        sram_wdata = (sy == '0) ? EMPTY_COLOR : sram_rdata;
      end
      default: ;
    endcase
  end

  // Detection outputs: the pulse coincides with the read of the last cell.
  always_comb begin
    clr_pulse     = row_full;
    clr_row       = row_full ? y : clr_row_q;
    lines_cleared = lines_cleared_q;
  end

endmodule

// File: tb/tb_tetris_row_clear.sv
// Directed bench for tetris_row_clear: a 4x4 instance exercises scan/shift
// behaviour, a default-size instance checks pass timing with start held high.
module tb_tetris_row_clear;

  logic clk;
  logic reset;

  // 4x4 instance signals
  logic       start4;
  logic [2:0] rd4;
  logic       busy4, done4, clr_pulse4, re4, we4;
  logic [2:0] lc4;
  logic [1:0] clr_row4, x4, y4;
  logic [2:0] wd4;

  // default-size instance signals
  logic       startd;
  logic [2:0] rdd;
  logic       busyd, doned, clr_pulsed, red, wed;
  logic [5:0] lcd;
  logic [5:0] clr_rowd, yd;
  logic [4:0] xd;
  logic [2:0] wdd;

  logic [2:0] mem4 [16];
  logic [2:0] img4 [16];
  logic       ld4;
  logic [2:0] memd [861];
  logic       ldd;

  int checks = 0;
  int errors = 0;
  int overlap = 0;

  int r_done_cyc, r_busy_cyc, r_busy_first, r_busy_last, r_re, r_we;
  logic [2:0] r_lines;
  logic       r_idle_after;
  logic [1:0] r_rows [$];

  tetris_row_clear #(.BOARD_W(4), .BOARD_H(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sram_rdata(rd4),
    .busy(busy4), .done(done4), .lines_cleared(lc4), .clr_pulse(clr_pulse4),
    .clr_row(clr_row4), .sram_re(re4), .sram_we(we4), .sram_x(x4),
    .sram_y(y4), .sram_wdata(wd4)
  );

  tetris_row_clear dutd (
    .clk(clk), .reset(reset), .start(startd), .sram_rdata(rdd),
    .busy(busyd), .done(doned), .lines_cleared(lcd), .clr_pulse(clr_pulsed),
    .clr_row(clr_rowd), .sram_re(red), .sram_we(wed), .sram_x(xd),
    .sram_y(yd), .sram_wdata(wdd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models, 1-cycle read latency; bulk load from the bench image.
  always @(posedge clk) begin
    if (ld4) mem4 <= img4;
    else if (we4) mem4[{y4, x4}] <= wd4;
    if (re4) rd4 <= mem4[{y4, x4}];
  end

  always @(posedge clk) begin
    if (ldd) begin
      for (int i = 0; i < 861; i++) memd[i] <= 3'd7;
    end else if (wed) begin
      memd[int'(yd) * 21 + int'(xd)] <= wdd;
    end
    if (red) rdd <= memd[int'(yd) * 21 + int'(xd)];
  end

  always @(negedge clk) begin
    if ((re4 && we4) || (red && wed)) overlap++;
  end

  task automatic set_row(input int row, input logic [2:0] c0, input logic [2:0] c1,
                         input logic [2:0] c2, input logic [2:0] c3);
    img4[row*4+0] = c0;
    img4[row*4+1] = c1;
    img4[row*4+2] = c2;
    img4[row*4+3] = c3;
  endtask

  task automatic load_board();
    @(negedge clk);
    ld4 = 1'b1;
    @(negedge clk);
    ld4 = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 16; i++) img4[i] = 3'd7;
  endtask

  task automatic run4(input int budget);
    r_done_cyc = 0; r_busy_cyc = 0; r_busy_first = 0; r_busy_last = 0;
    r_re = 0; r_we = 0; r_lines = '0; r_idle_after = 1'b0;
    r_rows.delete();
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (c == 1) start4 = 1'b0;
      if (r_done_cyc != 0) begin
        r_idle_after = !busy4;
        break;
      end
      if (busy4) begin
        r_busy_cyc++;
        if (r_busy_first == 0) r_busy_first = c;
        r_busy_last = c;
      end
      if (re4) r_re++;
      if (we4) r_we++;
      if (clr_pulse4) r_rows.push_back(clr_row4);
      if (done4) begin
        r_done_cyc = c;
        r_lines = lc4;
      end
    end
    start4 = 1'b0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_board(input string name);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem4[i] !== img4[i]) begin
        errors++;
        $display("FAIL %s cell y=%0d x=%0d got %0d want %0d", name, i / 4, i % 4, mem4[i], img4[i]);
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy4, done4, lc4, clr_pulse4, clr_row4, re4, we4, x4, y4, wd4} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_4x4 got %b want all zero",
               {busy4, done4, lc4, clr_pulse4, clr_row4, re4, we4, x4, y4, wd4});
    end
    checks++;
    if ({busyd, doned, lcd, clr_pulsed, clr_rowd, red, wed, xd, yd, wdd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_default got %b want all zero",
               {busyd, doned, lcd, clr_pulsed, clr_rowd, red, wed, xd, yd, wdd});
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_empty_board();
    clear_img();
    load_board();
    run4(40);
    check_int("empty_done_cycle", r_done_cyc, 9);
    check_int("empty_lines", int'(r_lines), 0);
    check_int("empty_writes", r_we, 0);
    check_int("empty_reads", r_re, 4);
    check_int("empty_busy_first", r_busy_first, 1);
    check_int("empty_busy_last", r_busy_last, 9);
    check_int("empty_busy_cycles", r_busy_cyc, 9);
    check_int("empty_idle_after", int'(r_idle_after), 1);
    check_int("empty_lines_held", int'(lc4), 0);
  endtask

  task automatic test_single_row();
    clear_img();
    set_row(3, 3'd2, 3'd2, 3'd2, 3'd2);
    load_board();
    run4(120);
    check_int("single_done_cycle", r_done_cyc, 49);
    check_int("single_lines", int'(r_lines), 1);
    check_int("single_pulses", r_rows.size(), 1);
    if (r_rows.size() > 0) check_int("single_clr_row", int'(r_rows[0]), 3);
    check_int("single_reads", r_re, 20);
    check_int("single_writes", r_we, 16);
    check_int("single_lines_held", int'(lc4), 1);
    clear_img();
    check_board("single_board");
  endtask

  task automatic test_two_rows();
    clear_img();
    set_row(3, 3'd2, 3'd2, 3'd2, 3'd2);
    set_row(2, 3'd2, 3'd2, 3'd2, 3'd2);
    set_row(1, 3'd2, 3'd7, 3'd7, 3'd7);
    load_board();
    run4(200);
    check_int("two_done_cycle", r_done_cyc, 91);
    check_int("two_lines", int'(r_lines), 2);
    check_int("two_pulses", r_rows.size(), 2);
    foreach (r_rows[i]) check_int("two_clr_row", int'(r_rows[i]), 3);
    check_int("two_reads", r_re, 37);
    check_int("two_writes", r_we, 32);
    clear_img();
    set_row(3, 3'd2, 3'd7, 3'd7, 3'd7);
    check_board("two_board");
  endtask

  task automatic test_full_board();
    for (int i = 0; i < 16; i++) img4[i] = 3'd5;
    load_board();
    run4(300);
    check_int("full_done_cycle", r_done_cyc, 169);
    check_int("full_lines", int'(r_lines), 4);
    check_int("full_pulses", r_rows.size(), 4);
    foreach (r_rows[i]) check_int("full_clr_row", int'(r_rows[i]), 3);
    // Any read issued while shifting into row 0 would raise this count.
    check_int("full_reads", r_re, 68);
    check_int("full_writes", r_we, 64);
    clear_img();
    check_board("full_board");
  endtask

  task automatic test_reset_mid_pass();
    bit seen;
    clear_img();
    set_row(3, 3'd1, 3'd1, 3'd1, 3'd1);
    load_board();
    @(negedge clk);
    start4 = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (we4) begin
        seen = 1'b1;
        break;
      end
    end
    check_int("midreset_reached_shift_wr", int'(seen), 1);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, lc4, clr_pulse4, clr_row4, re4, we4, x4, y4, wd4} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want all zero",
               {busy4, done4, lc4, clr_pulse4, clr_row4, re4, we4, x4, y4, wd4});
    end
    @(negedge clk);
    reset = 1'b1;
    clear_img();
    load_board();
    run4(40);
    check_int("midreset_rerun_done_cycle", r_done_cyc, 9);
    check_int("midreset_rerun_lines", int'(r_lines), 0);
  endtask

  task automatic test_start_held();
    int ndone, first_done, second_done;
    logic busy84, busy85;
    ndone = 0; first_done = 0; second_done = 0; busy84 = 1'b1; busy85 = 1'b0;
    @(negedge clk);
    ldd = 1'b1;
    @(negedge clk);
    ldd = 1'b0;
    startd = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 90) startd = 1'b0;
      if (c == 84) busy84 = busyd;
      if (c == 85) busy85 = busyd;
      if (doned) begin
        ndone++;
        if (ndone == 1) first_done = c;
        if (ndone == 2) second_done = c;
        checks++;
        if (lcd !== 6'd0) begin
          errors++;
          $display("FAIL held_lines got %0d want 0", lcd);
        end
      end
    end
    startd = 1'b0;
    check_int("held_first_done", first_done, 83);
    check_int("held_idle_gap", int'(busy84), 0);
    check_int("held_restart", int'(busy85), 1);
    check_int("held_second_done", second_done, 167);
    check_int("held_done_count", ndone, 2);
  endtask

  initial begin
    reset = 1'b0;
    start4 = 1'b0;
    startd = 1'b0;
    ld4 = 1'b0;
    ldd = 1'b0;
    test_reset();
    test_empty_board();
    test_single_row();
    test_two_rows();
    test_full_board();
    test_reset_mid_pass();
    test_start_held();
    check_int("re_we_overlap", overlap, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
